// File: rtl/uart_wb_arbiter.sv
// Two-master round-robin arbiter in front of the uart Wishbone-style slave port.
// Define UART_ARB_TIMEOUT_EN to build the watchdog that force-completes unacknowledged transactions.
module uart_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_stb,
  input  logic       m0_wb_clk,
  input  logic       m0_we,
  input  logic [1:0] m0_addr,
  input  logic [7:0] m0_data_in,
  output logic [7:0] m0_data_out,
  output logic       m0_ack,
  input  logic       m1_stb,
  input  logic       m1_wb_clk,
  input  logic       m1_we,
  input  logic [1:0] m1_addr,
  input  logic [7:0] m1_data_in,
  output logic [7:0] m1_data_out,
  output logic       m1_ack,
  output logic       s_stb,
  output logic       s_wb_clk,
  output logic       s_we,
  output logic [1:0] s_addr,
  output logic [7:0] s_data_out,
  input  logic [7:0] s_data_in,
  input  logic       s_ack,
  output logic [1:0] grant,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t     r_state, w_state_nxt;
  logic [1:0] r_grant, w_grant_nxt;
  logic       r_last, w_last_nxt;
  logic       r_forced, w_forced_nxt;
  logic [1:0] w_req;
  logic       w_sel, w_g_stb, w_g_wbclk, w_g_we, w_fwd, w_timeout;
  logic [1:0] w_g_addr;
  logic [7:0] w_g_data;

  assign w_req     = {m1_stb & m1_wb_clk, m0_stb & m0_wb_clk};
  assign w_sel     = r_grant[1];
  assign w_g_stb   = w_sel ? m1_stb     : m0_stb;
  assign w_g_wbclk = w_sel ? m1_wb_clk  : m0_wb_clk;
  assign w_g_we    = w_sel ? m1_we      : m0_we;
  assign w_g_addr  = w_sel ? m1_addr    : m0_addr;
  assign w_g_data  = w_sel ? m1_data_in : m0_data_in;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt;
  logic        r_terr;

  // Counter idles at zero outside BUSY, so every BUSY entry starts from a clean count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else begin
      r_cnt  <= (r_state == BUSY) ? r_cnt + 16'd1 : '0;
      r_terr <= r_terr | w_timeout;
    end
  end

  assign w_timeout   = (r_state == BUSY) && !s_ack && (r_cnt == TO_LAST);
  assign timeout_err = r_terr;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_grant  <= 2'b00;
      r_last   <= 1'b1;
      r_forced <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_forced <= w_forced_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    w_forced_nxt = r_forced;
    case (r_state)
      IDLE: begin
        // A lingering ack belongs to an aborted or reset transaction; wait it out.
        if (!s_ack && (w_req != 2'b00)) begin
          w_state_nxt = BUSY;
          if (w_req == 2'b11) w_grant_nxt = r_last ? 2'b01 : 2'b10;
          else                w_grant_nxt = w_req;
        end
      end
      BUSY: begin
        if (s_ack) begin
          w_state_nxt = RELEASE;
        end else if (w_timeout) begin
          w_state_nxt  = RELEASE;
          w_forced_nxt = 1'b1;
        end else if (!w_g_stb) begin
          w_state_nxt = IDLE;
          w_grant_nxt = 2'b00;
          w_last_nxt  = w_sel;
        end
      end
      RELEASE: begin
        if ((r_forced || !s_ack) && !w_g_wbclk) begin
          w_state_nxt  = IDLE;
          w_grant_nxt  = 2'b00;
          w_last_nxt   = w_sel;
          w_forced_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_grant_nxt  = 2'b00;
        w_forced_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_fwd       = (r_state != IDLE) && !r_forced;
    s_stb       = w_fwd & w_g_stb;
    s_wb_clk    = w_fwd & w_g_wbclk;
    s_we        = w_fwd & w_g_we;
    s_addr      = w_fwd ? w_g_addr : 2'b00;
    s_data_out  = w_fwd ? w_g_data : 8'h00;
    m0_ack      = r_grant[0] & (s_ack | r_forced);
    m1_ack      = r_grant[1] & (s_ack | r_forced);
    m0_data_out = r_grant[0] ? (r_forced ? 8'hFF : s_data_in) : 8'h00;
    m1_data_out = r_grant[1] ? (r_forced ? 8'hFF : s_data_in) : 8'h00;
    grant       = r_grant;
  end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Directed bench for uart_wb_arbiter: bench plays both masters and the uart slave,
// a scoreboard checks every new grant against the queued expected transaction.
module tb_uart_wb_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0]      m_stb = '0, m_wbclk = '0, m_we = '0;
  logic [1:0][1:0] m_addr = '0;
  logic [1:0][7:0] m_din = '0;
  wire  [1:0]      m_ack;
  wire  [1:0][7:0] m_dout;
  logic [7:0] s_data_in = 8'h00;
  logic       s_ack = 1'b0;
  wire        s_stb, s_wb_clk, s_we, timeout_err;
  wire  [1:0] s_addr, grant;
  wire  [7:0] s_data_out;

  typedef struct packed {
    logic [1:0] g;
    logic       we;
    logic [1:0] addr;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0, n_err = 0;
  logic [1:0] prev_g = 2'b00;

  uart_wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m0_stb(m_stb[0]), .m0_wb_clk(m_wbclk[0]), .m0_we(m_we[0]), .m0_addr(m_addr[0]),
    .m0_data_in(m_din[0]), .m0_data_out(m_dout[0]), .m0_ack(m_ack[0]),
    .m1_stb(m_stb[1]), .m1_wb_clk(m_wbclk[1]), .m1_we(m_we[1]), .m1_addr(m_addr[1]),
    .m1_data_in(m_din[1]), .m1_data_out(m_dout[1]), .m1_ack(m_ack[1]),
    .s_stb(s_stb), .s_wb_clk(s_wb_clk), .s_we(s_we), .s_addr(s_addr),
    .s_data_out(s_data_out), .s_data_in(s_data_in), .s_ack(s_ack),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each fresh grant must match the oldest queued transaction.
  always @(negedge clk) begin
    if (reset && grant != 2'b00 && prev_g == 2'b00) begin
      if (q.size() == 0) chk("sb_unexpected_grant", 32'(grant), 32'(0));
      else begin
        mon_e = q.pop_front();
        chk("sb_grant", 32'(grant), 32'(mon_e.g));
        chk("sb_we", 32'(s_we), 32'(mon_e.we));
        chk("sb_addr", 32'(s_addr), 32'(mon_e.addr));
        chk("sb_data", 32'(s_data_out), 32'(mon_e.d));
      end
    end
    prev_g = grant;
  end

  task automatic push(input logic [1:0] g, input logic we, input logic [1:0] a, input logic [7:0] d);
    exp_t e;
    e.g = g; e.we = we; e.addr = a; e.d = d;
    q.push_back(e);
  endtask

  task automatic req(input int n, input logic we, input logic [1:0] a, input logic [7:0] d);
    m_stb[n] = 1'b1; m_wbclk[n] = 1'b1; m_we[n] = we; m_addr[n] = a; m_din[n] = d;
  endtask

  task automatic drop(input int n);
    m_stb[n] = 1'b0; m_wbclk[n] = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != 2'b00) begin ok = 1'b1; break; end
    end
    if (!ok) chk("grant_timeout", 32'(grant), 32'(1));
  endtask

  task automatic pulse_reset();
    m_stb = '0; m_wbclk = '0; s_ack = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  // Slave acks the current owner, owner releases, slave drops ack; optionally owner re-requests.
  task automatic serve(input int n, input logic [7:0] rd, input bit rereq);
    bit ok;
    int o;
    o = 1 - n;
    wait_grant(ok);
    if (!ok) return;
    chk($sformatf("grant_m%0d", n), 32'(grant), 32'(1 << n));
    chk("s_stb_busy", 32'(s_stb), 32'(1));
    chk("ack_before_s_ack", 32'(m_ack[n]), 32'(0));
    @(posedge clk); #1 s_ack = 1'b1; s_data_in = rd;
    #1;
    chk($sformatf("ack_m%0d", n), 32'(m_ack[n]), 32'(1));
    chk($sformatf("ack_other_m%0d", o), 32'(m_ack[o]), 32'(0));
    chk($sformatf("dout_m%0d", n), 32'(m_dout[n]), 32'(rd));
    chk($sformatf("dout_other_m%0d", o), 32'(m_dout[o]), 32'(0));
    @(posedge clk); #1 drop(n);
    #1 chk("ack_held_release", 32'(m_ack[n]), 32'(1));
    @(posedge clk); #1 s_ack = 1'b0;
    @(posedge clk); #1;
    chk("grant_cleared", 32'(grant), 32'(0));
    if (rereq) begin m_stb[n] = 1'b1; m_wbclk[n] = 1'b1; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bit ok;
    // Reset state, even with a master requesting and the slave acking.
    req(0, 1'b0, 2'd0, 8'h41);
    s_ack = 1'b1; s_data_in = 8'hAA;
    #12;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_s_stb", 32'(s_stb), 32'(0));
    chk("rst_s_wb_clk", 32'(s_wb_clk), 32'(0));
    chk("rst_s_data_out", 32'(s_data_out), 32'(0));
    chk("rst_ack", 32'(m_ack), 32'(0));
    chk("rst_dout", 32'(m_dout), 32'(0));
    chk("rst_terr", 32'(timeout_err), 32'(0));
    drop(0); s_ack = 1'b0; s_data_in = 8'h00;
    @(posedge clk); #1 reset = 1'b1;

    // m0 write 0x41 to addr 0.
    @(posedge clk); #1;
    push(2'b01, 1'b0, 2'd0, 8'h41);
    req(0, 1'b0, 2'd0, 8'h41);
    serve(0, 8'h5A, 1'b0);

    // Simultaneous reads after reset: m0 first, then m1.
    pulse_reset();
    push(2'b01, 1'b1, 2'd1, 8'h00);
    push(2'b10, 1'b1, 2'd1, 8'h00);
    req(0, 1'b1, 2'd1, 8'h00);
    req(1, 1'b1, 2'd1, 8'h00);
    serve(0, 8'h11, 1'b0);
    serve(1, 8'h22, 1'b0);

    // Continuous contention: six alternating grants.
    for (int i = 0; i < 6; i++) push((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 2'(i % 4), 8'(8'h60 + i % 2));
    @(posedge clk); #1;
    req(0, 1'b0, 2'd0, 8'h60);
    req(1, 1'b0, 2'd1, 8'h61);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) m_addr[0] = 2'(i % 4);
      else            m_addr[1] = 2'(i % 4);
      serve(i % 2, 8'(8'h90 + i), i < 4);
    end

    // Abort: m1 drops stb while BUSY; stale ack then blocks re-arbitration.
    push(2'b10, 1'b0, 2'd2, 8'h77);
    req(1, 1'b0, 2'd2, 8'h77);
    wait_grant(ok);
    chk("abort_grant", 32'(grant), 32'(2'b10));
    @(posedge clk); #1 drop(1);
    chk("abort_no_ack_busy", 32'(m_ack[1]), 32'(0));
    @(posedge clk); #1;
    chk("abort_grant_clr", 32'(grant), 32'(0));
    chk("abort_no_ack", 32'(m_ack[1]), 32'(0));
    s_ack = 1'b1;
    push(2'b01, 1'b1, 2'd3, 8'h00);
    push(2'b10, 1'b0, 2'd2, 8'h77);
    req(0, 1'b1, 2'd3, 8'h00);
    req(1, 1'b0, 2'd2, 8'h77);
    @(negedge clk) chk("stale_ack_hold0", 32'(grant), 32'(0));
    @(negedge clk) chk("stale_ack_hold1", 32'(grant), 32'(0));
    @(posedge clk); #1 s_ack = 1'b0;
    serve(0, 8'h33, 1'b0);
    serve(1, 8'h44, 1'b0);

    // Reset asserted in RELEASE.
    push(2'b10, 1'b1, 2'd1, 8'h00);
    req(1, 1'b1, 2'd1, 8'h00);
    wait_grant(ok);
    @(posedge clk); #1 s_ack = 1'b1; s_data_in = 8'hC3;
    @(posedge clk); #1 reset = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 32'(0));
    chk("midrst_s_stb", 32'(s_stb), 32'(0));
    chk("midrst_s_wb_clk", 32'(s_wb_clk), 32'(0));
    chk("midrst_ack", 32'(m_ack[1]), 32'(0));
    chk("midrst_dout", 32'(m_dout[1]), 32'(0));
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk) chk("postrst_hold0", 32'(grant), 32'(0));
    @(negedge clk) chk("postrst_hold1", 32'(grant), 32'(0));
    push(2'b10, 1'b1, 2'd1, 8'h00);
    @(posedge clk); #1 s_ack = 1'b0;
    serve(1, 8'h5C, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog with TIMEOUT_CYCLES = 8: slave never acks.
    pulse_reset();
    push(2'b01, 1'b1, 2'd0, 8'h00);
    req(0, 1'b1, 2'd0, 8'h00);
    wait_grant(ok);
    for (int i = 0; i < 7; i++) @(negedge clk) chk("wd_no_ack", 32'(m_ack[0]), 32'(0));
    @(negedge clk);
    chk("wd_ack", 32'(m_ack[0]), 32'(1));
    chk("wd_dout", 32'(m_dout[0]), 32'(8'hFF));
    chk("wd_terr", 32'(timeout_err), 32'(1));
    chk("wd_s_stb", 32'(s_stb), 32'(0));
    @(posedge clk); #1 drop(0);
    @(posedge clk); #1;
    chk("wd_grant_clr", 32'(grant), 32'(0));
    chk("wd_terr_sticky", 32'(timeout_err), 32'(1));
`else
    chk("terr_tied", 32'(timeout_err), 32'(0));
`endif

    chk("sb_empty", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_wb_arbiter.md
# uart_wb_arbiter

Two-master arbiter that shares the single Wishbone-style slave port of the `uart` block between two requesters, e.g. the CPU and a boot/debug loader. It sits directly in front of `uart`, grants one transaction at a time with round-robin fairness, and forwards the `wb_stb`/`wb_clk`/`wb_ack` handshake unchanged. An optional watchdog completes transactions the slave never acknowledges.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1023: cycles in BUSY without `s_ack` before the watchdog fires. Only used with `UART_ARB_TIMEOUT_EN`; range 1..65535.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_stb`, `m1_stb`  in  1  master strobe.
- `m0_wb_clk`, `m1_wb_clk`  in  1  master transaction phase; high requests, low releases.
- `m0_we`, `m1_we`  in  1  master direction, using the uart convention: 0 = write, 1 = read.
- `m0_addr`, `m1_addr`  in  2  uart register address.
- `m0_data_in`, `m1_data_in`  in  8  write data.
- `m0_data_out`, `m1_data_out`  out  8  read data.
- `m0_ack`, `m1_ack`  out  1  acknowledge to master.
- `s_stb`, `s_wb_clk`, `s_we`  out  1  to uart `wb_stb`, `wb_clk`, `wb_we`.
- `s_addr`  out  2  to uart `wb_addr`.
- `s_data_out`  out  8  to uart `wb_data_in`.
- `s_data_in`  in  8  from uart `wb_data_out`.
- `s_ack`  in  1  from uart `wb_ack`.
- `grant`  out  2  one-hot current owner; 00 = none.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation

- **Request.** Master N requests when `mN_stb & mN_wb_clk`.
- **State register.** `state` ∈ {IDLE, BUSY, RELEASE}. `last` holds the index of the last master served. Reset sets `last = 1`, so m0 wins the first tie.
- **IDLE**
  - Stay in IDLE while `s_ack = 1` (stale ack from an aborted transaction).
  - Otherwise, if any request is present, latch the winner into `grant` and go to BUSY.
  - Single requester: that requester wins.
  - Both requesting: the master ≠ `last` wins.
- **BUSY**
  - Slave outputs are a combinational mux of the granted master's `stb`, `wb_clk`, `we`, `addr` and `data_in`.
  - On `s_ack = 1`, go to RELEASE.
  - If the granted master drops `mN_stb` before `s_ack` (abort), go to IDLE with no ack and set `last = N`.
- **RELEASE**
  - `mN_ack` follows `s_ack`.
  - When `s_ack = 0` and `mN_wb_clk = 0`, clear `grant`, set `last = N`, and go to IDLE.
- **Idle outputs.** With no grant, all `s_*` outputs are 0.
- **Ack and read data.**
  - `mN_ack = s_ack & grant[N]`.
  - `mN_data_out = grant[N] ? s_data_in : 8'h00`.
  - The non-granted master always sees ack 0 and data 0x00.
- **Reset mid-transaction.** Outputs drop immediately and `state = IDLE`. The uart completes its own handshake independently; the stale-ack rule above absorbs it.
- **Reset values.** `grant = 00`, all `s_*` = 0, `m*_ack = 0`, `m*_data_out = 0`, `timeout_err = 0`.

## Timing

- Request sampled at edge k → `grant` and `s_stb` high from edge k (registered grant) → visible to the uart at edge k+1. Arbitration latency is 1 cycle.
- Ack path (`s_ack` → `mN_ack`) is combinational, 0 cycles. Read data is combinational from `s_data_in`.
- Minimum back-to-back gap between grants: 1 IDLE cycle after RELEASE exits.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, …. Neither master waits more than one full transaction.
- A request arriving during BUSY or RELEASE is held off. It is served in the first IDLE cycle.

## Configuration

- **Macro:** `UART_ARB_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches `TIMEOUT_CYCLES` without `s_ack`:
    - Go to RELEASE with a forced ack: `mN_ack = 1` and `mN_data_out = 8'hFF` until `mN_wb_clk = 0`.
    - Drop all `s_*` to 0.
    - Set `timeout_err = 1`.
  - `timeout_err` clears only on reset.
- **Undefined:**
  - No counter is built; `timeout_err` is tied to 0.
  - BUSY waits indefinitely for `s_ack`.

## Test plan

- **Write via m0 only.** m0 requests a write of 0x41 to addr 00 → `grant = 01` the cycle after the request; `s_data_out = 0x41`, `s_we = 0`; `m0_ack` mirrors `s_ack`; `m1_ack` stays 0.
- **Simultaneous requests after reset.** m0 and m1 request reads of addr 01 in the same cycle → m0 is served first, then m1; `m1_data_out` = uart value, `m0_data_out = 0x00` during m1's grant.
- **Continuous contention.** Both masters request continuously for 6 transactions → grant order 01, 10, 01, 10, 01, 10.
- **Abort before ack.** m1 drops `stb` while BUSY, before `s_ack` → IDLE, no `m1_ack`; a following m1 request is granted once `s_ack` is low.
- **Reset mid-transaction.** Assert `reset = 0` in RELEASE → all outputs 0 asynchronously; after release, no grant until `s_ack = 0`.
- **Watchdog (`UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES = 8`).** Slave never acks → `m0_ack = 1` with data 0xFF at BUSY cycle 8; `timeout_err = 1` and sticky.
